caravel_fpga: RTL and testbench

// - Top-level FPGA stand-in for the Caravel management SoC.
// - Boots from an external SPI flash (read cmd 0x03) and executes a 2-byte command stream.
// - Commands drive the mgmt `gpio` pin and the `mprj_io` user pads.
// - No CPU: a fetch/execute FSM replaces the firmware core.

---
 rtl/caravel_fpga_if.sv | 11 +
 rtl/caravel_fpga.sv | 172 +++++++++++++++++
 tb/tb_caravel_fpga.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/caravel_fpga_if.sv
// SPI flash boot bus between the caravel_fpga stand-in (master) and the
// external flash (slave). Mode 0, single-bit MOSI/MISO.
interface caravel_fpga_if;
  logic flash_csb;
  logic flash_clk;
  logic flash_io0;
  logic flash_io1;

  modport master (output flash_csb, output flash_clk, output flash_io0, input flash_io1);
  modport slave  (input flash_csb, input flash_clk, input flash_io0, output flash_io1);
endinterface

// File: rtl/caravel_fpga.sv
// Caravel management SoC stand-in: fetches 2-byte commands from SPI flash and
// drives gpio / mprj_io. Define BLINK_COUNT_EN to count gpio falls on mprj_io[15:8].
//
// state  | meaning
// IDLE   | post-reset, start first fetch
// FETCH  | SPI read of opcode/operand at pc
// EXEC   | apply command, release flash
// WAIT   | hold until synced lo equals operand
// DELAY  | down-count operand*DELAY_UNIT cycles
// HALT   | frozen until reset
module caravel_fpga #(
  parameter int unsigned SPI_DIV    = 1,
  parameter int unsigned DELAY_UNIT = 256,
  parameter logic [23:0] BOOT_ADDR  = 24'h0
) (
  input  logic           clk_osc,
  input  logic           FPGA_rst,
  output logic           gpio,
  inout  wire  [37:0]    mprj_io,
  caravel_fpga_if.master flash
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DELAY,
    S_HALT
  } state_t;

  localparam logic [7:0]  CMD_READ = 8'h03;
  localparam logic [15:0] DIV_LOAD = 16'(SPI_DIV - 1);
  localparam logic [31:0] DLY_UNIT = 32'(DELAY_UNIT);

  state_t      r_state;
  logic [23:0] r_pc;
  logic        r_csb;
  logic        r_sck;
  logic        r_mosi;
  logic [31:0] r_tx;
  logic [15:0] r_rx;
  logic [5:0]  r_bit_cnt;
  logic [15:0] r_div;
  logic [31:0] r_dly;
  logic        r_gpio;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo_s1;
  logic [7:0]  r_lo_s2;

  wire  [7:0]  w_op = r_rx[15:8];
  wire  [7:0]  w_n  = r_rx[7:0];

  always_ff @(posedge clk_osc) begin
    if (FPGA_rst) begin
      r_lo_s1 <= 8'h00;
      r_lo_s2 <= 8'h00;
    end else begin
      r_lo_s1 <= mprj_io[23:16];
      r_lo_s2 <= r_lo_s1;
    end
  end

  always_ff @(posedge clk_osc) begin
    if (FPGA_rst) begin
      r_state   <= S_IDLE;
      r_pc      <= BOOT_ADDR;
      r_csb     <= 1'b1;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_tx      <= 32'h0;
      r_rx      <= 16'h0;
      r_bit_cnt <= 6'd0;
      r_div     <= 16'd0;
      r_dly     <= 32'd0;
      r_gpio    <= 1'b0;
      r_hi      <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;

        S_FETCH: begin
          if (r_csb) begin
            // CSB has been high for at least one cycle; open the transaction
            r_csb     <= 1'b0;
            r_sck     <= 1'b0;
            r_tx      <= {CMD_READ, r_pc};
            r_mosi    <= CMD_READ[7];
            r_bit_cnt <= 6'd0;
            r_div     <= DIV_LOAD;
          end else if (r_div != 16'd0) begin
            r_div <= r_div - 16'd1;
          end else begin
            r_div <= DIV_LOAD;
            if (!r_sck) begin
              r_sck <= 1'b1;
              if (r_bit_cnt >= 6'd32) r_rx <= {r_rx[14:0], flash.flash_io1};
              if (r_bit_cnt == 6'd47) begin
                r_state <= S_EXEC;
                r_pc    <= r_pc + 24'd2;
              end
            end else begin
              r_sck     <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 6'd1;
              r_tx      <= {r_tx[30:0], 1'b0};
              r_mosi    <= r_tx[30];
            end
          end
        end

        S_EXEC: begin
          r_csb   <= 1'b1;
          r_sck   <= 1'b0;
          r_mosi  <= 1'b0;
          r_state <= S_FETCH;
          case (w_op)
            8'h01: r_gpio <= w_n[0];
            8'h02: r_hi <= w_n;
            8'h03: r_hi <= r_lo_s2 + w_n;
            8'h04: begin
              if (w_n != 8'h00) begin
                r_dly   <= ({24'd0, w_n} * DLY_UNIT) - 32'd1;
                r_state <= S_DELAY;
              end
            end
            8'h05: if (r_lo_s2 != w_n) r_state <= S_WAIT;
            8'h06: r_pc <= {15'b0, w_n, 1'b0};
            8'hFF: r_state <= S_HALT;
            default: ;
          endcase
        end

        S_WAIT: if (r_lo_s2 == w_n) r_state <= S_FETCH;

        S_DELAY: begin
          if (r_dly == 32'd0) r_state <= S_FETCH;
          else r_dly <= r_dly - 32'd1;
        end

        S_HALT: r_csb <= 1'b1;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gpio            = r_gpio;
  assign flash.flash_csb = r_csb;
  assign flash.flash_clk = r_sck;
  assign flash.flash_io0 = r_mosi;

  assign mprj_io[37:32] = 6'bz;
  assign mprj_io[31:24] = r_hi;
  assign mprj_io[7:0]   = 8'bz;

`ifdef BLINK_COUNT_EN
  logic [7:0] r_blink;

  // gpio only changes in EXEC, so a 1->0 fall is an 0x01 command clearing a set pin
  always_ff @(posedge clk_osc) begin
    if (FPGA_rst) r_blink <= 8'd0;
    else if (r_state == S_EXEC && w_op == 8'h01 && r_gpio && !w_n[0]) r_blink <= r_blink + 8'd1;
  end

  assign mprj_io[15:8] = r_blink;
`else
  assign mprj_io[15:8] = 8'bz;
`endif

  wire w_unused_pads = ^{mprj_io[37:32], mprj_io[15:0]};

endmodule

// File: tb/tb_caravel_fpga.sv
// Scoreboard bench for caravel_fpga: a flash model serves commands, monitors
// compare completed fetch headers and mprj_io[31:24] updates against queues.
module tb_caravel_fpga;
  logic       clk_osc  = 1'b0;
  logic       FPGA_rst = 1'b1;
  logic       gpio;
  wire [37:0] mprj_io;
  logic [7:0] r_lo = 8'h00;

  assign mprj_io[23:16] = r_lo;

  caravel_fpga_if u_if ();

  caravel_fpga dut (
    .clk_osc (clk_osc),
    .FPGA_rst(FPGA_rst),
    .gpio    (gpio),
    .mprj_io (mprj_io),
    .flash   (u_if)
  );

  always #5 clk_osc = ~clk_osc;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:255];
  logic [31:0] exp_txn[$];
  logic [7:0]  exp_hi[$];
  int          n_txn = 0;

  // flash model
  int          bitn = 0;
  logic [31:0] hdr  = 32'h0;
  logic [15:0] word = 16'h0;

  initial u_if.flash_io1 = 1'b0;

  always @(negedge u_if.flash_csb) bitn = 0;

  always @(posedge u_if.flash_clk) begin
    if (!u_if.flash_csb) begin
      if (bitn < 32) hdr = {hdr[30:0], u_if.flash_io0};
      bitn++;
      if (bitn == 32) word = {mem[hdr[7:0]], mem[hdr[7:0] + 8'd1]};
    end
  end

  always @(negedge u_if.flash_clk) begin
    if (!u_if.flash_csb && bitn >= 32 && bitn < 48) u_if.flash_io1 = word[47 - bitn];
  end

  // monitors
  logic        prev_csb  = 1'b1;
  logic [7:0]  prev_hi   = 8'h00;
  logic        prev_gpio = 1'b0;
  int          hi_len    = 0;
  int          pulses    = 0;
  logic [31:0] e_txn;
  logic [7:0]  e_hi;

  always @(negedge clk_osc) begin
    if (!prev_csb && u_if.flash_csb && bitn == 48) begin
      n_txn++;
      checks++;
      if (exp_txn.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected got=%h", hdr);
      end else begin
        e_txn = exp_txn.pop_front();
        if (hdr !== e_txn) begin
          errors++;
          $display("FAIL fetch_header got=%h exp=%h", hdr, e_txn);
        end
      end
    end
    prev_csb = u_if.flash_csb;

    if (mprj_io[31:24] !== prev_hi && !FPGA_rst) begin
      checks++;
      if (exp_hi.size() == 0) begin
        errors++;
        $display("FAIL hi_unexpected got=%h", mprj_io[31:24]);
      end else begin
        e_hi = exp_hi.pop_front();
        if (mprj_io[31:24] !== e_hi) begin
          errors++;
          $display("FAIL hi_update got=%h exp=%h", mprj_io[31:24], e_hi);
        end
      end
    end
    prev_hi = mprj_io[31:24];

    if (gpio && !prev_gpio) hi_len = 0;
    if (gpio) hi_len++;
    if (!gpio && prev_gpio && !FPGA_rst) begin
      pulses++;
      checks++;
      if (hi_len < 256) begin
        errors++;
        $display("FAIL gpio_pulse_width got=%0d exp>=256", hi_len);
      end
    end
    prev_gpio = gpio;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_txn(input int target, input int budget);
    int i = 0;
    while (n_txn < target && i < budget) begin
      @(negedge clk_osc);
      i++;
    end
    chk("fetch_count_timeout", 32'(n_txn >= target), 32'd1);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk_osc);
    FPGA_rst = 1'b1;
    repeat (cycles) @(negedge clk_osc);
  endtask

  task automatic load_blink();
    for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      mem[8*k+0] = 8'h01; mem[8*k+1] = 8'h01;
      mem[8*k+2] = 8'h04; mem[8*k+3] = 8'h01;
      mem[8*k+4] = 8'h01; mem[8*k+5] = 8'h00;
      mem[8*k+6] = 8'h04; mem[8*k+7] = 8'h01;
    end
    mem[80] = 8'hFF; mem[81] = 8'h00;
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3; mem[4] = b4; mem[5] = b5;
  endtask

  int base;
  int t;

  initial begin
    // reset state and blink program
    load_blink();
    repeat (100) @(negedge clk_osc);
    chk("rst_csb", 32'(u_if.flash_csb), 32'd1);
    chk("rst_sck", 32'(u_if.flash_clk), 32'd0);
    chk("rst_mosi", 32'(u_if.flash_io0), 32'd0);
    chk("rst_gpio", 32'(gpio), 32'd0);
    chk("rst_hi", 32'(mprj_io[31:24]), 32'h00);
`ifdef BLINK_COUNT_EN
    chk("rst_blink", 32'(mprj_io[15:8]), 32'h00);
`endif
    for (int a = 0; a <= 80; a += 2) exp_txn.push_back({8'h03, 24'(a)});
    pulses = 0;
    FPGA_rst = 1'b0;
    wait_txn(41, 20000);
    repeat (600) @(negedge clk_osc);
    chk("blink_pulses", 32'(pulses), 32'd10);
    chk("halt_csb", 32'(u_if.flash_csb), 32'd1);
    chk("halt_no_fetch", 32'(n_txn), 32'd41);
    chk("halt_gpio", 32'(gpio), 32'd0);
`ifdef BLINK_COUNT_EN
    chk("blink_count", 32'(mprj_io[15:8]), 32'd10);
`endif

    // hi = lo + n, plain and wrapping
    load_prog(8'h03, 8'h10, 8'hFF, 8'h00, 8'hFF, 8'hFF);
    r_lo = 8'h05;
    apply_reset(20);
    base = n_txn;
    exp_txn.push_back(32'h03000000);
    exp_txn.push_back(32'h03000002);
    exp_hi.push_back(8'h15);
    FPGA_rst = 1'b0;
    wait_txn(base + 2, 1000);
    repeat (10) @(negedge clk_osc);
    chk("add_hi", 32'(mprj_io[31:24]), 32'h15);

    r_lo = 8'hF8;
    apply_reset(20);
    base = n_txn;
    exp_txn.push_back(32'h03000000);
    exp_txn.push_back(32'h03000002);
    exp_hi.push_back(8'h08);
    FPGA_rst = 1'b0;
    wait_txn(base + 2, 1000);
    repeat (10) @(negedge clk_osc);
    chk("add_wrap_hi", 32'(mprj_io[31:24]), 32'h08);

    // WAIT on lo, then load hi
    load_prog(8'h05, 8'hA5, 8'h02, 8'h3C, 8'hFF, 8'h00);
    r_lo = 8'h00;
    apply_reset(20);
    base = n_txn;
    exp_txn.push_back(32'h03000000);
    FPGA_rst = 1'b0;
    wait_txn(base + 1, 1000);
    repeat (300) @(negedge clk_osc);
    chk("wait_hi_held", 32'(mprj_io[31:24]), 32'h00);
    chk("wait_no_fetch", 32'(n_txn), 32'(base + 1));
    exp_txn.push_back(32'h03000002);
    exp_txn.push_back(32'h03000004);
    exp_hi.push_back(8'h3C);
    r_lo = 8'hA5;
    // 2-flop sync + one full 48-bit fetch at SPI_DIV=1 + exec
    t = 0;
    while (mprj_io[31:24] !== 8'h3C && t < 150) begin
      @(negedge clk_osc);
      t++;
    end
    chk("wait_release_hi", 32'(mprj_io[31:24]), 32'h3C);
    wait_txn(base + 3, 1000);

    // reset in the middle of a fetch
    load_blink();
    apply_reset(20);
    base = n_txn;
    for (int a = 0; a <= 10; a += 2) exp_txn.push_back({8'h03, 24'(a)});
    FPGA_rst = 1'b0;
    wait_txn(base + 6, 5000);
`ifdef BLINK_COUNT_EN
    chk("pre_abort_blink", 32'(mprj_io[15:8]), 32'd1);
`endif
    t = 0;
    while (!(!u_if.flash_csb && bitn >= 12) && t < 2000) begin
      @(negedge clk_osc);
      t++;
    end
    chk("midfetch_reached", 32'(!u_if.flash_csb && bitn >= 12), 32'd1);
    FPGA_rst = 1'b1;
    @(negedge clk_osc);
    chk("abort_csb", 32'(u_if.flash_csb), 32'd1);
    chk("abort_gpio", 32'(gpio), 32'd0);
`ifdef BLINK_COUNT_EN
    chk("abort_blink", 32'(mprj_io[15:8]), 32'd0);
`endif
    repeat (4) @(negedge clk_osc);
    base = n_txn;
    exp_txn.push_back(32'h03000000);
    exp_txn.push_back(32'h03000002);
    FPGA_rst = 1'b0;
    wait_txn(base + 2, 1000);

    chk("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
    chk("hi_queue_drained", 32'(exp_hi.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=%0d txns exp=finish", n_txn);
    $fatal(1, "watchdog");
  end

endmodule
